// File: rtl/mem_copy_engine_pkg.sv
// ----------------------------------------------------------------------------
// mem_copy_engine_pkg
//   Shared definitions for the block copy/fill engine and any future arbiter
//   that muxes the data-memory port on the engine's busy flag.
//   Contents:
//     MCE_AW / MCE_DW / MCE_LW  default address, data and length widths
//     mce_state_e               FSM state encoding (IDLE/RD/WR/DONE)
// ----------------------------------------------------------------------------
package mem_copy_engine_pkg;

    localparam int MCE_AW = 16;
    localparam int MCE_DW = 16;
    localparam int MCE_LW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } mce_state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// ----------------------------------------------------------------------------
// mem_copy_engine
//   Bus-master block mover on the data-memory port. Copies len words from
//   src_addr to dst_addr (ascending, one read then one write per word) or
//   fills len words at dst_addr with fill_value (one write per word).
//
//   Ports
//     clk, rst_n                 clock (rising edge), async active-low reset
//     start                      one-cycle command strobe, taken only in IDLE
//     fill_mode                  0 = copy, 1 = fill
//     src_addr, dst_addr, len    command operands
//     fill_value                 constant written in fill mode
//     busy                       command in progress (RD/WR/DONE)
//     done                       one-cycle completion pulse
//     words_done                 words written by current/last command
//     mem_access_addr            shared read/write word address
//     mem_write_data             write data
//     mem_write_en               write strobe (memory writes on clk rise)
//     mem_read                   read strobe
//     mem_read_data              combinational read data
//     dbg_state                  current FSM state, for observation only
//
//   Handshake: start is a fire-and-forget strobe; it is accepted only when the
//   engine is IDLE and silently dropped otherwise. done pulses for exactly one
//   cycle per accepted command; there is no backpressure on the memory port.
//
//   All memory-side outputs are flops loaded with the value for the state being
//   entered, so nothing on the memory port depends combinationally on inputs.
// ----------------------------------------------------------------------------
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int AW = MCE_AW,
    parameter int DW = MCE_DW,
    parameter int LW = MCE_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fill_mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] words_done,
    output logic [AW-1:0] mem_access_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_write_en,
    output logic          mem_read,
    input  logic [DW-1:0] mem_read_data,
    output logic [1:0]    dbg_state
);

    mce_state_e    state_q;
    logic [AW-1:0] src_ptr_q;
    logic [AW-1:0] dst_ptr_q;
    logic [LW-1:0] remaining_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] fill_value_q;
    logic          fill_mode_q;
    logic [LW-1:0] words_done_q;

    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            data_q       <= '0;
            fill_value_q <= '0;
            fill_mode_q  <= 1'b0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
        end else begin
            // Strobes default low; each transition below raises only the one
            // belonging to the state being entered, so read and write can
            // never coincide.
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    addr_q  <= '0;
                    wdata_q <= '0;
                    busy_q  <= 1'b0;
                    if (start) begin
                        src_ptr_q    <= src_addr;
                        dst_ptr_q    <= dst_addr;
                        remaining_q  <= len;
                        fill_value_q <= fill_value;
                        fill_mode_q  <= fill_mode;
                        words_done_q <= '0;
                        busy_q       <= 1'b1;
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (fill_mode) begin
                            state_q <= ST_WR;
                            we_q    <= 1'b1;
                            addr_q  <= dst_addr;
                            wdata_q <= fill_value;
                        end else begin
                            state_q <= ST_RD;
                            rd_q    <= 1'b1;
                            addr_q  <= src_addr;
                        end
                    end
                end

                ST_RD: begin
                    data_q    <= mem_read_data;
                    src_ptr_q <= src_ptr_q + AW'(1);
                    state_q   <= ST_WR;
                    we_q      <= 1'b1;
                    addr_q    <= dst_ptr_q;
                    // Captured word goes straight onto the write bus for WR.
                    wdata_q   <= mem_read_data;
                end

                ST_WR: begin
                    dst_ptr_q    <= dst_ptr_q + AW'(1);
                    remaining_q  <= remaining_q - LW'(1);
                    words_done_q <= words_done_q + LW'(1);
                    if (remaining_q == LW'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end else if (fill_mode_q) begin
                        state_q <= ST_WR;
                        we_q    <= 1'b1;
                        addr_q  <= dst_ptr_q + AW'(1);
                        wdata_q <= fill_value_q;
                    end else begin
                        // src_ptr_q was already advanced during RD.
                        state_q <= ST_RD;
                        rd_q    <= 1'b1;
                        addr_q  <= src_ptr_q;
                        wdata_q <= '0;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign words_done      = words_done_q;
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;
    assign mem_write_en    = we_q;
    assign mem_read        = rd_q;
    assign dbg_state       = state_q;

    // data_q holds the last copied word for observation; the write path uses
    // the copy already placed in wdata_q.
    logic unused_data;
    assign unused_data = ^data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_engine
//   Directed bench for mem_copy_engine with a 64K-word behavioural memory.
// ----------------------------------------------------------------------------
module tb_mem_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        fill_mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:65535];
    logic [15:0] wr_addrs[$];

    int total_cnt;
    int pass_cnt;

    int done_cyc, n_wr, n_rd, n_done, n_both;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .fill_mode       (fill_mode),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len             (len),
        .fill_value      (fill_value),
        .busy            (busy),
        .done            (done),
        .words_done      (words_done),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .dbg_state       (dbg_state)
    );

    // behavioural memory: combinational read gated by mem_read, write on rise
    assign mem_read_data = mem_read ? mem[mem_access_addr] : 16'h0000;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Issue one command and watch the port for win cycles after the accepting
    // edge E0. xs: cycle in which a second start is driven (0 = none).
    // ab: cycle in which rst_n is pulled low and the task returns (0 = none).
    task automatic run_cmd(input logic fm, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [15:0] fv,
                           input int xs, input int ab, input int win);
        done_cyc = -1; n_wr = 0; n_rd = 0; n_done = 0; n_both = 0;
        wr_addrs.delete();
        fill_mode = fm; src_addr = s; dst_addr = d; len = l; fill_value = fv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= win; c++) begin
            if (ab == c) begin
                rst_n = 1'b0;
                #1;
                break;
            end
            start = (xs == c);
            if (mem_write_en) begin
                n_wr++;
                wr_addrs.push_back(mem_access_addr);
            end
            if (mem_read) n_rd++;
            if (mem_read && mem_write_en) n_both++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; fill_mode = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_value = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) mem[i] = 16'h1111 * 16'(i + 1);
        total_cnt = 0; pass_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words_done", words_done, 0);
        chk("rst_addr", mem_access_addr, 0);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_we", mem_write_en, 0);
        chk("rst_rd", mem_read, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // copy 0..2 -> 4..6
        run_cmd(1'b0, 16'h0000, 16'h0004, 16'd3, 16'h0000, 0, 0, 10);
        chk("copy_done_cyc", done_cyc, 7);
        chk("copy_n_done", n_done, 1);
        chk("copy_n_wr", n_wr, 3);
        chk("copy_n_rd", n_rd, 3);
        chk("copy_both", n_both, 0);
        chk("copy_m4", mem[4], 16'h1111);
        chk("copy_m5", mem[5], 16'h2222);
        chk("copy_m6", mem[6], 16'h3333);
        chk("copy_m7", mem[7], 16'h8888);
        chk("copy_words_done", words_done, 3);
        chk("copy_busy_end", busy, 0);

        // fill 2..5 with A5A5
        run_cmd(1'b1, 16'h0000, 16'h0002, 16'd4, 16'hA5A5, 0, 0, 8);
        chk("fill_done_cyc", done_cyc, 5);
        chk("fill_n_wr", n_wr, 4);
        chk("fill_n_rd", n_rd, 0);
        chk("fill_both", n_both, 0);
        chk("fill_m1", mem[1], 16'h2222);
        chk("fill_m2", mem[2], 16'hA5A5);
        chk("fill_m5", mem[5], 16'hA5A5);
        chk("fill_m6", mem[6], 16'h3333);
        chk("fill_words_done", words_done, 4);

        // zero length
        run_cmd(1'b0, 16'h0000, 16'h0003, 16'd0, 16'h0000, 0, 0, 4);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_n_done", n_done, 1);
        chk("len0_n_wr", n_wr, 0);
        chk("len0_n_rd", n_rd, 0);
        chk("len0_m3", mem[3], 16'hA5A5);
        chk("len0_words_done", words_done, 0);

        // address wrap
        run_cmd(1'b1, 16'h0000, 16'hFFFF, 16'd2, 16'h5A5A, 0, 0, 5);
        chk("wrap_done_cyc", done_cyc, 3);
        chk("wrap_n_wr", n_wr, 2);
        chk("wrap_addr0", (wr_addrs.size() > 0) ? wr_addrs[0] : 16'hDEAD, 16'hFFFF);
        chk("wrap_addr1", (wr_addrs.size() > 1) ? wr_addrs[1] : 16'hDEAD, 16'h0000);
        chk("wrap_mFFFF", mem[16'hFFFF], 16'h5A5A);
        chk("wrap_m0", mem[0], 16'h5A5A);

        // start while busy is ignored
        mem[8] = 16'hB001; mem[9] = 16'hB002; mem[10] = 16'hB003;
        run_cmd(1'b0, 16'h0008, 16'h0010, 16'd3, 16'h0000, 2, 0, 20);
        chk("busy_done_cyc", done_cyc, 7);
        chk("busy_n_done", n_done, 1);
        chk("busy_n_wr", n_wr, 3);
        chk("busy_both", n_both, 0);
        chk("busy_m10", mem[16'h10], 16'hB001);
        chk("busy_m12", mem[16'h12], 16'hB003);
        chk("busy_m13", mem[16'h13], 16'h0000);

        // overlapping dst = src+1 smears the first word
        mem[16'h50] = 16'h7777; mem[16'h51] = 16'h0001; mem[16'h52] = 16'h0002;
        run_cmd(1'b0, 16'h0050, 16'h0051, 16'd2, 16'h0000, 0, 0, 8);
        chk("smear_done_cyc", done_cyc, 5);
        chk("smear_m51", mem[16'h51], 16'h7777);
        chk("smear_m52", mem[16'h52], 16'h7777);

        // reset during second WR of a 3-word copy
        mem[16'h30] = 16'hC001; mem[16'h31] = 16'hC002; mem[16'h32] = 16'hC003;
        run_cmd(1'b0, 16'h0030, 16'h0040, 16'd3, 16'h0000, 0, 4, 10);
        chk("abort_we", mem_write_en, 0);
        chk("abort_rd", mem_read, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_words_done", words_done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_m40", mem[16'h40], 16'hC001);
        chk("abort_m41", mem[16'h41], 16'h0000);
        chk("abort_m42", mem[16'h42], 16'h0000);
        chk("abort_state", dbg_state, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
